hex_entry_ctrl: RTL and testbench

HEX_ENTRY_CTRL -- requirements
Module: hex_entry_ctrl

---
 rtl/hex_entry_ctrl.sv | 154 +++++++++++++++
 tb/tb_hex_entry_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_entry_ctrl.sv
// Hex keypad entry controller: collects two operands of up to three hex
// digits each, issues them as a pair, and signals the end of an operation
// sequence. Rejected keys produce a one-cycle key_err pulse.
module hex_entry_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic        key_ready,
  output logic [11:0] num1_hex,
  output logic [11:0] num2_hex,
  output logic        new_input,
  output logic        finish_input,
  output logic [11:0] entry_val,
  output logic [2:0]  state_o,
  output logic        key_err
);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_ISSUE   = 3'd2,
    S_FIN     = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e      state_q;
  logic [11:0] buf_a_q, buf_b_q;
  logic [1:0]  cnt_a_q, cnt_b_q;
  logic [11:0] num1_q, num2_q;
  logic        new_q, fin_q, err_q;

  logic        is_digit, is_enter, is_clear, is_finish;
  logic [1:0]  cur_cnt;
  logic [11:0] cur_buf;
  logic [11:0] buf_shift_d;

  // Key decode and the shifted value of whichever buffer is being edited
  always_comb begin
    is_digit    = (key_code[4] == 1'b0);
    is_enter    = (key_code == 5'h10);
    is_clear    = (key_code == 5'h11);
    is_finish   = (key_code == 5'h12);
    cur_cnt     = (state_q == S_ENTER_B) ? cnt_b_q : cnt_a_q;
    cur_buf     = (state_q == S_ENTER_B) ? buf_b_q : buf_a_q;
    buf_shift_d = {cur_buf[7:0], key_code[3:0]};
  end

  // Entry FSM with registered operand and pulse outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_ENTER_A;
      buf_a_q <= 12'h000;
      buf_b_q <= 12'h000;
      cnt_a_q <= 2'd0;
      cnt_b_q <= 2'd0;
      num1_q  <= 12'h000;
      num2_q  <= 12'h000;
      new_q   <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      new_q <= 1'b0;
      fin_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_ENTER_A, S_ENTER_B: begin
          if (key_valid) begin
            if (is_digit) begin
              // A full buffer refuses further digits rather than shifting out
              if (cur_cnt == 2'd3) begin
                err_q <= 1'b1;
              end else if (state_q == S_ENTER_A) begin
                buf_a_q <= buf_shift_d;
                cnt_a_q <= cnt_a_q + 2'd1;
              end else begin
                buf_b_q <= buf_shift_d;
                cnt_b_q <= cnt_b_q + 2'd1;
              end
            end else if (is_enter) begin
              if (cur_cnt == 2'd0) begin
                err_q <= 1'b1;
              end else if (state_q == S_ENTER_A) begin
                state_q <= S_ENTER_B;
                buf_b_q <= 12'h000;
                cnt_b_q <= 2'd0;
              end else begin
                state_q <= S_ISSUE;
              end
            end else if (is_clear || is_finish) begin
              // Both discard any partially entered operands
              buf_a_q <= 12'h000;
              buf_b_q <= 12'h000;
              cnt_a_q <= 2'd0;
              cnt_b_q <= 2'd0;
              state_q <= is_clear ? S_ENTER_A : S_FIN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          num1_q  <= buf_a_q;
          num2_q  <= buf_b_q;
          new_q   <= 1'b1;
          buf_a_q <= 12'h000;
          buf_b_q <= 12'h000;
          cnt_a_q <= 2'd0;
          cnt_b_q <= 2'd0;
          state_q <= S_ENTER_A;
          err_q   <= key_valid;
        end
        S_FIN: begin
          fin_q   <= 1'b1;
          state_q <= S_DONE;
          err_q   <= key_valid;
        end
        S_DONE: begin
          if (key_valid) begin
            if (is_clear) begin
              buf_a_q <= 12'h000;
              buf_b_q <= 12'h000;
              cnt_a_q <= 2'd0;
              cnt_b_q <= 2'd0;
              state_q <= S_ENTER_A;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_ENTER_A;
      endcase
    end
  end

  // Output decode: readiness follows state and is forced low while in reset
  always_comb begin
    key_ready = rst & ((state_q == S_ENTER_A) || (state_q == S_ENTER_B) ||
                       (state_q == S_DONE));
    case (state_q)
      S_ENTER_A: entry_val = buf_a_q;
      S_ENTER_B: entry_val = buf_b_q;
      default:   entry_val = 12'h000;
    endcase
  end

  assign num1_hex     = num1_q;
  assign num2_hex     = num2_q;
  assign new_input    = new_q;
  assign finish_input = fin_q;
  assign key_err      = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Bench for hex_entry_ctrl: a queue-based model of operand entry checked
// against the DUT every cycle, plus directed scenarios with literal results.
module tb_hex_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = 5'h00;
  logic        key_ready;
  logic [11:0] num1_hex, num2_hex, entry_val;
  logic        new_input, finish_input, key_err;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  hex_entry_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .num1_hex(num1_hex), .num2_hex(num2_hex),
    .new_input(new_input), .finish_input(finish_input),
    .entry_val(entry_val), .state_o(state_o), .key_err(key_err)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int cnt_new = 0, cnt_fin = 0, cnt_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase = 0;   // 0 A, 1 B, 2 issue, 3 fin, 4 done
  int          qa[$];
  int          qb[$];
  logic [11:0] m_n1 = 12'h000, m_n2 = 12'h000;
  bit          m_new = 1'b0, m_fin = 1'b0, m_err = 1'b0;

  function automatic logic [11:0] val(input int q[$]);
    int v;
    v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v[11:0];
  endfunction

  always @(posedge clk or negedge rst) begin : model
    int c;
    if (!rst) begin
      m_phase = 0; qa.delete(); qb.delete();
      m_n1 = 12'h000; m_n2 = 12'h000;
      m_new = 1'b0; m_fin = 1'b0; m_err = 1'b0;
    end else begin
      m_new = 1'b0; m_fin = 1'b0; m_err = 1'b0;
      c = int'(key_code);
      if (m_phase == 2) begin
        m_n1 = val(qa); m_n2 = val(qb); m_new = 1'b1;
        qa.delete(); qb.delete(); m_phase = 0; m_err = key_valid;
      end else if (m_phase == 3) begin
        m_fin = 1'b1; m_phase = 4; m_err = key_valid;
      end else if (key_valid) begin
        if (c >= 'h13) m_err = 1'b1;
        else if (c == 'h11) begin qa.delete(); qb.delete(); m_phase = 0; end
        else if (m_phase == 4) m_err = 1'b1;
        else if (c == 'h12) begin qa.delete(); qb.delete(); m_phase = 3; end
        else if (c == 'h10) begin
          if ((m_phase == 0 ? qa.size() : qb.size()) == 0) m_err = 1'b1;
          else if (m_phase == 0) begin qb.delete(); m_phase = 1; end
          else m_phase = 2;
        end else if (m_phase == 0) begin
          if (qa.size() < 3) qa.push_back(c); else m_err = 1'b1;
        end else begin
          if (qb.size() < 3) qb.push_back(c); else m_err = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", state_o, m_phase);
      chk("ready", key_ready, rst && (m_phase == 0 || m_phase == 1 || m_phase == 4));
      chk("entry", entry_val, m_phase == 0 ? val(qa) : (m_phase == 1 ? val(qb) : 12'h000));
      chk("num1", num1_hex, m_n1);
      chk("num2", num2_hex, m_n2);
      chk("new", new_input, m_new);
      chk("fin", finish_input, m_fin);
      chk("err", key_err, m_err);
      chk("excl", new_input && finish_input, 0);
      cnt_new += int'(new_input);
      cnt_fin += int'(finish_input);
      cnt_err += int'(key_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic key(input logic [4:0] c);
    @(negedge clk); #1;
    key_valid = 1'b1; key_code = c;
    @(negedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int s, s2;
    #3 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk); #1;
    chk("rst_state", state_o, 0);
    chk("rst_ready", key_ready, 0);
    chk("rst_num1", num1_hex, 0);
    chk("rst_new", new_input, 0);
    chk("rst_err", key_err, 0);
    @(negedge clk); #1 rst = 1'b1;

    // basic issue with explicit latency
    s = cnt_new;
    key(5'h05); key(5'h10); key(5'h03);
    @(negedge clk); #1 key_valid = 1'b1; key_code = 5'h10;
    @(negedge clk);
    chk("lat_issue_state", state_o, 2);
    chk("lat_issue_new", new_input, 0);
    #1 key_valid = 1'b0;
    @(negedge clk);
    chk("lat_new", new_input, 1);
    chk("lat_num1", num1_hex, 12'h005);
    chk("lat_num2", num2_hex, 12'h003);
    chk("lat_state", state_o, 0);
    idle(2);
    chk("basic_pulses", cnt_new - s, 1);

    // overflow
    s = cnt_err;
    key(5'h0A); key(5'h0B); key(5'h0C);
    chk("ovf_no_err_yet", cnt_err - s, 0);
    key(5'h0D);
    chk("ovf_err", cnt_err - s, 1);
    chk("ovf_entry", entry_val, 12'hABC);
    key(5'h10); key(5'h0F); key(5'h10); idle(2);
    chk("ovf_num1", num1_hex, 12'hABC);
    chk("ovf_num2", num2_hex, 12'h00F);

    // empty enter and invalid code
    s = cnt_err; s2 = cnt_new;
    key(5'h10); idle(1);
    chk("empty_err", cnt_err - s, 1);
    chk("empty_state", state_o, 0);
    chk("empty_new", cnt_new - s2, 0);
    key(5'h15); idle(1);
    chk("inval_err", cnt_err - s, 2);

    // finish and clear
    s = cnt_fin; s2 = cnt_new;
    key(5'h01); key(5'h10); key(5'h02); key(5'h12); idle(2);
    chk("fin_pulse", cnt_fin - s, 1);
    chk("fin_new", cnt_new - s2, 0);
    chk("fin_num1", num1_hex, 12'hABC);
    chk("fin_num2", num2_hex, 12'h00F);
    chk("fin_state", state_o, 4);
    s = cnt_err;
    key(5'h07); idle(1);
    chk("done_err", cnt_err - s, 1);
    chk("done_state", state_o, 4);
    s = cnt_err;
    key(5'h11); idle(1);
    chk("clr_state", state_o, 0);
    chk("clr_noerr", cnt_err - s, 0);

    // busy drop during issue
    key(5'h01); key(5'h10); key(5'h02);
    s = cnt_err;
    @(negedge clk); #1 key_valid = 1'b1; key_code = 5'h10;
    @(negedge clk); #1 key_code = 5'h09;
    @(negedge clk); #1 key_valid = 1'b0;
    idle(2);
    chk("busy_err", cnt_err - s, 1);
    chk("busy_entry", entry_val, 12'h000);
    chk("busy_num1", num1_hex, 12'h001);
    chk("busy_num2", num2_hex, 12'h002);

    // reset mid-entry
    key(5'h04); key(5'h02);
    chk("pre_rst_entry", entry_val, 12'h042);
    @(negedge clk); #1 rst = 1'b0;
    idle(2); #1;
    chk("rst_mid_entry", entry_val, 12'h000);
    chk("rst_mid_state", state_o, 0);
    chk("rst_mid_ready", key_ready, 0);
    rst = 1'b1;
    key(5'h01); key(5'h10); key(5'h01); key(5'h10); idle(2);
    chk("post_rst_num1", num1_hex, 12'h001);
    chk("post_rst_num2", num2_hex, 12'h001);

    // reset during issue suppresses the pulse
    s = cnt_new;
    key(5'h03); key(5'h10); key(5'h04);
    @(negedge clk); #1 key_valid = 1'b1; key_code = 5'h10;
    @(negedge clk); #1 rst = 1'b0; key_valid = 1'b0;
    idle(2); #1 rst = 1'b1;
    idle(2);
    chk("rst_issue_new", cnt_new - s, 0);
    chk("rst_issue_num1", num1_hex, 12'h000);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
